// File: rtl/multi_counter_pkg.sv
// Shared constants and the saturating/wrapping adder used by every counter channel.
package multi_counter_pkg;

    // Widest counter supported; the adder helper works at this width and masks down.
    localparam int unsigned MaxWidth = 64;

    // All-ones pattern at the maximum width; narrower counters mask it down.
    localparam logic [MaxWidth-1:0] AllOnes = {MaxWidth{1'b1}};

    // All-ones mask of the requested width, right-aligned in a MaxWidth word.
    function automatic logic [MaxWidth-1:0] ones_mask(input int unsigned width);
        logic [MaxWidth-1:0] mask;
        if (width >= MaxWidth) begin
            mask = AllOnes;
        end else begin
            mask = (64'd1 << width) - 64'd1;
        end
        return mask;
    endfunction

    // Unsigned add of count and step at the given width.
    // Returns {carry_out, next_value}; on carry-out in saturate mode the value pins to all-ones.
    function automatic logic [MaxWidth:0] sat_add(input logic [MaxWidth-1:0] count,
                                                  input logic [MaxWidth-1:0] step,
                                                  input logic                sat,
                                                  input int unsigned         width);
        logic [MaxWidth:0]   sum;
        logic [MaxWidth-1:0] mask;
        logic [MaxWidth-1:0] next;
        logic                c;
        mask = ones_mask(width);
        sum  = {1'b0, count} + {1'b0, step};
        c    = sum[width];
        next = sum[MaxWidth-1:0] & mask;
        if (c && sat) begin
            next = mask;
        end
        return {c, next};
    endfunction

endpackage

// File: rtl/counter_channel.sv
// One counter channel: count register with clr > load > en priority,
// one-cycle carry pulse and sticky overflow flag.
module counter_channel
    import multi_counter_pkg::*;
#(
    parameter int unsigned CounterWidth = 32,
    parameter int unsigned StepWidth    = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic [StepWidth-1:0]    step,
    input  logic                    sat_mode,
    input  logic                    clr,
    input  logic                    load,
    input  logic [CounterWidth-1:0] load_val,
    input  logic                    ovf_clr,
    output logic [CounterWidth-1:0] count,
    output logic                    carry,
    output logic                    ovf
);

    logic [CounterWidth-1:0] count_q, count_d;
    logic                    carry_q, carry_d;
    logic                    ovf_q, ovf_d;
    logic [CounterWidth-1:0] step_ext;
    logic [MaxWidth:0]       add_res;
    logic                    unused_add_bits;

    // Zero-extend the step to the counter width; no extension when widths match.
    generate
        if (StepWidth == CounterWidth) begin : g_step_same
            assign step_ext = step;
        end else begin : g_step_ext
            assign step_ext = {{(CounterWidth - StepWidth){1'b0}}, step};
        end
    endgenerate

    // Candidate increment result, evaluated every cycle and used only when enabled.
    assign add_res = sat_add(MaxWidth'(count_q), MaxWidth'(step_ext), sat_mode, CounterWidth);

    // Bits above the counter width are always zero after masking.
    assign unused_add_bits = ^(add_res[MaxWidth-1:0] & ~ones_mask(CounterWidth));

    // Next-state: clr beats load beats en; a fresh overflow beats ovf_clr.
    always_comb begin
        count_d = count_q;
        carry_d = 1'b0;
        ovf_d   = ovf_clr ? 1'b0 : ovf_q;
        if (clr) begin
            count_d = '0;
            ovf_d   = 1'b0;
        end else if (load) begin
            count_d = load_val;
        end else if (en) begin
            count_d = add_res[CounterWidth-1:0];
            if (add_res[MaxWidth]) begin
                carry_d = 1'b1;
                ovf_d   = 1'b1;
            end
        end
    end

    // Channel state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
        end
    end

    assign count = count_q;
    assign carry = carry_q;
    assign ovf   = ovf_q;

endmodule

// File: rtl/multi_channel_counter.sv
// NumChannels independent up-counters plus a coherent snapshot of all channels.
module multi_channel_counter
    import multi_counter_pkg::*;
#(
    parameter int unsigned NumChannels  = 4,
    parameter int unsigned CounterWidth = 32,
    parameter int unsigned StepWidth    = 8
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [NumChannels-1:0]              en,
    input  logic [NumChannels*StepWidth-1:0]    step,
    input  logic [NumChannels-1:0]              sat_mode,
    input  logic [NumChannels-1:0]              clr,
    input  logic [NumChannels-1:0]              load,
    input  logic [CounterWidth-1:0]             load_val,
    input  logic [NumChannels-1:0]              ovf_clr,
    input  logic                                snap,
    output logic [NumChannels*CounterWidth-1:0] count,
    output logic [NumChannels*CounterWidth-1:0] snap_count,
    output logic                                snap_valid,
    output logic [NumChannels-1:0]              carry,
    output logic [NumChannels-1:0]              ovf
);

    logic [NumChannels*CounterWidth-1:0] snap_count_q, snap_count_d;
    logic                                snap_valid_q, snap_valid_d;

    // One independent channel per counter; no carry chain between them.
    generate
        for (genvar i = 0; i < NumChannels; i++) begin : g_ch
            counter_channel #(
                .CounterWidth (CounterWidth),
                .StepWidth    (StepWidth)
            ) u_channel (
                .clk      (clk),
                .rst_n    (rst_n),
                .en       (en[i]),
                .step     (step[i*StepWidth +: StepWidth]),
                .sat_mode (sat_mode[i]),
                .clr      (clr[i]),
                .load     (load[i]),
                .load_val (load_val),
                .ovf_clr  (ovf_clr[i]),
                .count    (count[i*CounterWidth +: CounterWidth]),
                .carry    (carry[i]),
                .ovf      (ovf[i])
            );
        end
    endgenerate

    // Snapshot takes the currently visible counts, i.e. the values before this edge's update.
    always_comb begin
        snap_count_d = snap_count_q;
        snap_valid_d = snap_valid_q;
        if (snap) begin
            snap_count_d = count;
            snap_valid_d = 1'b1;
        end
    end

    // Snapshot registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snap_count_q <= '0;
            snap_valid_q <= 1'b0;
        end else begin
            snap_count_q <= snap_count_d;
            snap_valid_q <= snap_valid_d;
        end
    end

    assign snap_count = snap_count_q;
    assign snap_valid = snap_valid_q;

endmodule

// File: tb/tb_multi_channel_counter.sv
// Directed bench: a 4x32-bit counter (dut_a) and a 4x8-bit counter with 8-bit step (dut_b).
module tb_multi_channel_counter;

    logic clk;
    logic rst_n;

    // dut_a: 4 channels, 32-bit counters, 8-bit steps
    logic [3:0]   en_a, sat_a, clr_a, load_a, ovf_clr_a, carry_a, ovf_a;
    logic [31:0]  step_a, load_val_a;
    logic         snap_a, snap_valid_a;
    logic [127:0] count_a, snap_count_a;

    // dut_b: 4 channels, 8-bit counters, 8-bit steps
    logic [3:0]   en_b, sat_b, clr_b, load_b, ovf_clr_b, carry_b, ovf_b;
    logic [31:0]  step_b;
    logic [7:0]   load_val_b;
    logic         snap_b, snap_valid_b;
    logic [31:0]  count_b, snap_count_b;

    int checks;
    int errors;

    multi_channel_counter #(.NumChannels(4), .CounterWidth(32), .StepWidth(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .en(en_a), .step(step_a), .sat_mode(sat_a),
        .clr(clr_a), .load(load_a), .load_val(load_val_a), .ovf_clr(ovf_clr_a),
        .snap(snap_a), .count(count_a), .snap_count(snap_count_a),
        .snap_valid(snap_valid_a), .carry(carry_a), .ovf(ovf_a)
    );

    multi_channel_counter #(.NumChannels(4), .CounterWidth(8), .StepWidth(8)) dut_b (
        .clk(clk), .rst_n(rst_n), .en(en_b), .step(step_b), .sat_mode(sat_b),
        .clr(clr_b), .load(load_b), .load_val(load_val_b), .ovf_clr(ovf_clr_b),
        .snap(snap_b), .count(count_b), .snap_count(snap_count_b),
        .snap_valid(snap_valid_b), .carry(carry_b), .ovf(ovf_b)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        en_a = '0; sat_a = '0; clr_a = '0; load_a = '0; ovf_clr_a = '0;
        step_a = '0; load_val_a = '0; snap_a = 1'b0;
        en_b = '0; sat_b = '0; clr_b = '0; load_b = '0; ovf_clr_b = '0;
        step_b = '0; load_val_b = '0; snap_b = 1'b0;

        // Reset state
        #12;
        check("rst_count_a", count_a, 128'h0);
        check("rst_snap_a", snap_count_a, 128'h0);
        check("rst_snap_valid_a", {127'h0, snap_valid_a}, 128'h0);
        check("rst_carry_ovf_a", {120'h0, carry_a, ovf_a}, 128'h0);
        check("rst_count_b", {96'h0, count_b}, 128'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // ch0 counts by 1 for five cycles
        en_a = 4'b0001; step_a = 32'h0000_0001;
        repeat (5) tick();
        en_a = '0;
        check("cnt5_ch0", {96'h0, count_a[31:0]}, 128'd5);
        check("cnt5_others", {32'h0, count_a[127:32]}, 128'h0);
        check("cnt5_carry_ovf", {120'h0, carry_a, ovf_a}, 128'h0);

        // Two more increments to 7, then snap together with an increment
        en_a = 4'b0001;
        repeat (2) tick();
        check("cnt7_ch0", {96'h0, count_a[31:0]}, 128'd7);
        snap_a = 1'b1;
        tick();
        snap_a = 1'b0; en_a = '0;
        check("snap_ch0", {96'h0, snap_count_a[31:0]}, 128'd7);
        check("snap_live_ch0", {96'h0, count_a[31:0]}, 128'd8);
        check("snap_valid", {127'h0, snap_valid_a}, 128'h1);
        tick();
        check("snap_valid_hold", {127'h0, snap_valid_a}, 128'h1);
        check("snap_hold_all", snap_count_a, 128'h7);

        // 8-bit wrap on ch1: 0xFE + 3 -> 0x01, carry pulse, sticky ovf
        load_b = 4'b0010; load_val_b = 8'hFE;
        tick();
        load_b = '0;
        check("wrap_load", {120'h0, count_b[15:8]}, 128'hFE);
        en_b = 4'b0010; step_b = 32'h0000_0300; sat_b = '0;
        tick();
        en_b = '0;
        check("wrap_count", {120'h0, count_b[15:8]}, 128'h01);
        check("wrap_carry", {124'h0, carry_b}, 128'b0010);
        check("wrap_ovf", {124'h0, ovf_b}, 128'b0010);
        tick();
        check("wrap_carry_gone", {124'h0, carry_b}, 128'b0000);
        check("wrap_ovf_sticky", {124'h0, ovf_b}, 128'b0010);
        check("wrap_count_hold", {120'h0, count_b[15:8]}, 128'h01);

        // Saturate on ch1: clear ovf, reload 0xFE, then overflow twice
        ovf_clr_b = 4'b0010; load_b = 4'b0010;
        tick();
        ovf_clr_b = '0; load_b = '0;
        check("sat_ovf_cleared", {124'h0, ovf_b}, 128'h0);
        sat_b = 4'b0010; en_b = 4'b0010;
        tick();
        check("sat_count", {120'h0, count_b[15:8]}, 128'hFF);
        check("sat_carry", {124'h0, carry_b}, 128'b0010);
        check("sat_ovf", {124'h0, ovf_b}, 128'b0010);
        ovf_clr_b = 4'b0010;
        tick();
        ovf_clr_b = '0;
        check("sat2_count", {120'h0, count_b[15:8]}, 128'hFF);
        check("sat2_carry", {124'h0, carry_b}, 128'b0010);
        check("sat2_ovf_set_wins", {124'h0, ovf_b}, 128'b0010);
        step_b = 32'h0;
        tick();
        en_b = '0;
        check("step0_count", {120'h0, count_b[15:8]}, 128'hFF);
        check("step0_carry", {124'h0, carry_b}, 128'h0);
        ovf_clr_b = 4'b0010;
        tick();
        ovf_clr_b = '0;
        check("ovf_clr_alone", {124'h0, ovf_b}, 128'h0);

        // ch2: set ovf, then clr+load+en -> clr wins; then load+en -> load wins
        load_b = 4'b0100; load_val_b = 8'hFF;
        tick();
        load_b = '0; en_b = 4'b0100; step_b = 32'h0001_0000; sat_b = '0;
        tick();
        en_b = '0;
        check("ch2_wrap_count", {120'h0, count_b[23:16]}, 128'h00);
        check("ch2_ovf", {124'h0, ovf_b}, 128'b0100);
        en_b = 4'b0100; step_b = 32'h0005_0000;
        tick();
        check("ch2_pre_clr", {120'h0, count_b[23:16]}, 128'h05);
        clr_b = 4'b0100; load_b = 4'b0100; load_val_b = 8'h55;
        tick();
        clr_b = '0;
        check("clr_wins_count", {120'h0, count_b[23:16]}, 128'h00);
        check("clr_wins_ovf", {124'h0, ovf_b}, 128'h0);
        tick();
        load_b = '0; en_b = '0;
        check("load_wins_count", {120'h0, count_b[23:16]}, 128'h55);
        check("load_other_ch", {96'h0, count_b & 32'hFF00_FFFF}, 128'h0000_FF00);

        // Async reset mid-count: ch0 overflows (ovf=1), ch3 loaded to 0x1234
        load_a = 4'b0001; load_val_a = 32'hFFFF_FFFF;
        tick();
        load_a = 4'b1000; load_val_a = 32'h0000_1234;
        en_a = 4'b0001; step_a = 32'h0000_0001;
        tick();
        load_a = '0; en_a = '0;
        check("pre_rst_ch3", {96'h0, count_a[127:96]}, 128'h1234);
        check("pre_rst_ch0", {96'h0, count_a[31:0]}, 128'h0);
        check("pre_rst_ovf", {124'h0, ovf_a}, 128'b0001);
        check("pre_rst_carry", {124'h0, carry_a}, 128'b0001);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_count_a", count_a, 128'h0);
        check("arst_snap_a", snap_count_a, 128'h0);
        check("arst_flags_a", {119'h0, snap_valid_a, carry_a, ovf_a}, 128'h0);
        check("arst_count_b", {96'h0, count_b}, 128'h0);
        @(negedge clk);
        rst_n = 1'b1;
        en_a = 4'b1000; step_a = 32'h0200_0000;
        repeat (3) tick();
        en_a = '0;
        check("resume_ch3", {96'h0, count_a[127:96]}, 128'd6);
        check("resume_others", {32'h0, count_a[95:0]}, 128'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global time limit so the run always ends.
    initial begin
        #100000;
        errors++;
        $display("FAIL timeout: observed no finish expected finish before 100000");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
